// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Decoupling buffer between instruction_memory and the decode stage. Each
// accepted fetch address is remembered for one cycle (pend/pend_pc). The
// synchronous memory returns the instruction word in the following cycle, and
// the {pc, inst} pair is pushed into a small FIFO. Decode drains the FIFO
// through a valid/ready handshake. stall_fetch holds the pc register whenever
// the queue could not absorb another response. A flush (branch redirect)
// discards everything queued or in flight, but still accepts the redirect
// target that is presented in the same cycle.
//
// Ports
//   clock        rising-edge clock shared with pc and instruction_memory
//   reset        synchronous, active-high
//   req_valid    a fetch address is presented to the memory this cycle
//   req_pc       that address
//   inst         memory read data, belonging to the previous accepted request
//   flush        branch redirect; empties the queue and drops the pending fetch
//   stall_fetch  pc must hold; a request presented while high is ignored
//   out_valid    head entry is valid
//   out_pc       address of the head entry
//   out_inst     instruction word of the head entry
//   out_ready    decode consumes the head entry when out_valid is also high
//   count        number of occupied entries
// ---------------------------------------------------------------------------
`ifndef PC_ADDR_WIDTH
`define PC_ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module inst_fetch_queue #(
    parameter int PC_W   = `PC_ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [PC_W-1:0]            req_pc,
    input  logic [DATA_W-1:0]          inst,
    input  logic                       flush,
    output logic                       stall_fetch,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [DATA_W-1:0]          out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Entry storage, pointers and occupancy.
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [CW-1:0]     count_reg;

    // Outstanding memory read issued in the previous cycle.
    logic              pend_reg;
    logic [PC_W-1:0]   pend_pc_reg;

    logic              acc;
    logic              push;
    logic              pop;
    logic [CW:0]       credit_used;

    // Credits are counted against entries already stored plus the response
    // still in flight, so a push can never find the FIFO full. During a flush
    // the queue is about to be emptied, so the redirect target is always taken.
    always_comb begin
        credit_used = {1'b0, count_reg} + {{CW{1'b0}}, pend_reg};
        stall_fetch = ~flush & (credit_used >= (CW+1)'(DEPTH));
        acc         = req_valid & ~stall_fetch;
        push        = pend_reg & ~flush;
        pop         = (count_reg != '0) & out_ready & ~flush;
    end

    assign out_valid = (count_reg != '0);
    assign out_pc    = pc_mem[rd_ptr_reg];
    assign out_inst  = inst_mem[rd_ptr_reg];
    assign count     = count_reg;

    // Pending-response tracker: reset drops a fetch in flight; a flush does not
    // block the redirect target from becoming the new pending fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_reg    <= 1'b0;
            pend_pc_reg <= '0;
        end else begin
            pend_reg    <= acc;
            pend_pc_reg <= req_pc;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage: cleared on reset so the head slot reads zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_reg]   <= pend_pc_reg;
            inst_mem[wr_ptr_reg] <= inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue (PC_W=16, DATA_W=32, DEPTH=4).
// A synchronous memory model returns {16'hC0DE, pc} one cycle after an
// address is presented. A queue-based reference model tracks the entries the
// decode stage should see; a compare process checks the DUT against it every
// cycle, and directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int PC_W   = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic [PC_W-1:0]   req_pc;
    logic [DATA_W-1:0] inst;
    logic              flush;
    logic              stall_fetch;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_inst;
    logic              out_ready;
    logic [CW-1:0]     count;

    inst_fetch_queue #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .inst        (inst),
        .flush       (flush),
        .stall_fetch (stall_fetch),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] memf(input logic [PC_W-1:0] pc);
        return {16'hC0DE, pc};
    endfunction

    // Synchronous instruction memory.
    always @(posedge clock) inst <= memf(req_pc);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: list of entries decode will see, plus the one
    // memory response in flight.
    // ------------------------------------------------------------------
    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] ins;
    } ent_t;

    ent_t            m_q[$];
    int              m_pend    = 0;
    logic [PC_W-1:0] m_pend_pc = '0;
    bit              live      = 1'b0;

    always @(posedge clock) begin
        bit   a;
        ent_t e;
        if (reset) begin
            m_q.delete();
            m_pend = 0;
            live   = 1'b1;
        end else if (flush) begin
            m_q.delete();
            m_pend    = req_valid ? 1 : 0;
            m_pend_pc = req_pc;
        end else begin
            a = req_valid && (m_q.size() + m_pend < DEPTH);
            if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (m_pend != 0) begin
                e.pc  = m_pend_pc;
                e.ins = memf(m_pend_pc);
                m_q.push_back(e);
            end
            m_pend    = a ? 1 : 0;
            m_pend_pc = req_pc;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        #2;
        if (live) begin
            check("cmp_count", 64'(count), 64'(m_q.size()));
            check("cmp_out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            check("cmp_stall", 64'(stall_fetch),
                  64'(!flush && (m_q.size() + m_pend >= DEPTH)));
            if (m_q.size() != 0) begin
                check("cmp_out_pc", 64'(out_pc), 64'(m_q[0].pc));
                check("cmp_out_inst", 64'(out_inst), 64'(m_q[0].ins));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: fetch_pc behaves like the pc register (advances only when a
    // request is accepted). Returns 1 ns after the edge that closes the cycle.
    // ------------------------------------------------------------------
    logic [PC_W-1:0] fetch_pc = '0;
    logic [PC_W-1:0] log_q[$];

    task automatic cyc(input bit rv, input bit rdy, input bit fl, input bit rs);
        bit will_acc;
        @(negedge clock);
        req_valid = rv;
        req_pc    = fetch_pc;
        out_ready = rdy;
        flush     = fl;
        reset     = rs;
        will_acc  = rv && !rs && (fl || (m_q.size() + m_pend < DEPTH));
        #3;
        if (!rs && !fl && out_valid && rdy) begin
            log_q.push_back(out_pc);
            $display("pop pc=%0d inst=%08h count=%0d", out_pc, out_inst, count);
        end
        @(posedge clock);
        #1;
        if (rs) fetch_pc = '0;
        else if (will_acc) fetch_pc = fetch_pc + 1'b1;
    endtask

    task automatic check_log(input string name, input int first, input int n);
        check({name, "_len"}, 64'(log_q.size()), 64'(n));
        for (int i = 0; i < n && i < log_q.size(); i++)
            check({name, "_order"}, 64'(log_q[i]), 64'(first + i));
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset state.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        check("rst_out_inst", 64'(out_inst), 64'(0));
        check("rst_stall", 64'(stall_fetch), 64'(0));

        // Free-running fetch: first output two cycles after release.
        cyc(1, 1, 0, 0);
        check("fr_valid_c1", 64'(out_valid), 64'(0));
        cyc(1, 1, 0, 0);
        check("fr_valid_c2", 64'(out_valid), 64'(1));
        check("fr_pc_c2", 64'(out_pc), 64'(0));
        check("fr_inst_c2", 64'(out_inst), 64'(32'hC0DE0000));
        for (int k = 3; k <= 12; k++) begin
            cyc(1, 1, 0, 0);
            check("fr_pc", 64'(out_pc), 64'(k - 2));
            check("fr_stall", 64'(stall_fetch), 64'(0));
            check("fr_count_le1", 64'(count <= 1), 64'(1));
        end

        // Backpressure: exactly DEPTH accepted, then drain 0..4.
        cyc(0, 0, 0, 1);
        log_q.delete();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        check("bp_count_sat", 64'(count), 64'(4));
        check("bp_stall", 64'(stall_fetch), 64'(1));
        check("bp_head", 64'(out_pc), 64'(0));
        for (int i = 0; i < 12; i++) begin
            cyc(fetch_pc <= 4, 1, 0, 0);
            if (i == 0) begin
                check("bp_stall_fall", 64'(stall_fetch), 64'(0));
                check("bp_count_after_pop", 64'(count), 64'(3));
            end
        end
        check_log("bp_drain", 0, 5);

        // Push and pop in the same cycle with the queue at its credit limit.
        cyc(0, 0, 0, 1);
        log_q.delete();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        check("pp_count_before", 64'(count), 64'(3));
        check("pp_stall_before", 64'(stall_fetch), 64'(1));
        cyc(1, 1, 0, 0);
        check("pp_count_same", 64'(count), 64'(3));
        check("pp_head_adv", 64'(out_pc), 64'(1));
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        check_log("pp_wrap", 0, 5);

        // Flush with entries queued and a fetch in flight.
        cyc(0, 0, 0, 1);
        log_q.delete();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        check("fl_count_before", 64'(count), 64'(3));
        fetch_pc = 16'd20;
        cyc(1, 1, 1, 0);
        check("fl_count_zero", 64'(count), 64'(0));
        check("fl_valid_zero", 64'(out_valid), 64'(0));
        cyc(0, 1, 0, 0);
        check("fl_target_valid", 64'(out_valid), 64'(1));
        check("fl_target_pc", 64'(out_pc), 64'(20));
        check("fl_target_inst", 64'(out_inst), 64'(32'hC0DE0014));
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        check_log("fl_only_target", 20, 1);

        // Wrap-around with random out_ready; bounded cycle budget.
        cyc(0, 0, 0, 1);
        log_q.delete();
        for (int i = 0; i < 300 && log_q.size() < 10; i++)
            cyc(fetch_pc < 10, 1'($urandom_range(0, 1)), 0, 0);
        check_log("wrap", 0, 10);

        // Reset mid-operation.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        check("mr_count_before", 64'(count), 64'(2));
        cyc(1, 1, 0, 1);
        check("mr_out_valid", 64'(out_valid), 64'(0));
        check("mr_count", 64'(count), 64'(0));
        check("mr_out_pc", 64'(out_pc), 64'(0));
        check("mr_out_inst", 64'(out_inst), 64'(0));
        check("mr_stall", 64'(stall_fetch), 64'(0));
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        check("mr_no_ghost", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
